// File: rtl/mxu_engine.sv
// Memory-mapped SIZE x SIZE matrix multiply engine.
// A and B are written through a simple write channel, a CTRL write launches
// C = A*B (or C += A*B), and A, B, C and STATUS are readable with a one-cycle
// registered read response. irq mirrors the sticky done flag.
module mxu_engine #(
  parameter int SIZE   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(SIZE)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        awready,
  output logic        wready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  localparam int NE = SIZE*SIZE;
  localparam int IW = $clog2(NE);
  localparam int CW = $clog2(SIZE);
  localparam logic [31:0] A_BASE = 32'd1;
  localparam logic [31:0] B_BASE = 32'(1 + NE);
  localparam logic [31:0] C_BASE = 32'(1 + 2*NE);
  localparam logic [31:0] U_BASE = 32'(1 + 3*NE);
  localparam logic [CW-1:0] CMAX = CW'(SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_FIN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] i_q, i_d, k_q, k_d;
  logic done_q, done_d, err_q, err_d;
  logic acc_q, acc_d, sgn_q, sgn_d;
  logic rvalid_q;
  logic [31:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] a_q [NE];
  logic [DATA_W-1:0] b_q [NE];
  logic [ACC_W-1:0]  c_q [NE];

  logic          wr_en, wr_ctrl, wr_a, wr_b, idle, start_acc, err_set;
  logic [31:0]   wa_off, wb_off, ra_off, rb_off, rc_off;
  logic [IW-1:0] a_idx;
  logic [IW-1:0] b_idx [SIZE];
  logic [IW-1:0] c_idx [SIZE];
  logic [ACC_W-1:0] mac [SIZE];

  // Operand extension to accumulator width, signed or unsigned
  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v, input logic s);
    logic [ACC_W-1:0] r;
    if (s) r = ACC_W'($signed(v));
    else   r = ACC_W'(v);
    return r;
  endfunction

  // Result extension to the 32-bit read bus, per latched signed_mode
  function automatic logic [31:0] cext(input logic [ACC_W-1:0] v, input logic s);
    logic [31:0] r;
    if (s) r = 32'($signed(v));
    else   r = 32'(v);
    return r;
  endfunction

  assign idle    = (state_q == S_IDLE);
  assign wr_en   = awvalid & wvalid;
  assign awready = wr_en;
  assign wready  = wr_en;
  assign irq     = done_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;

  // Write address decode and control-write side effects
  always_comb begin
    wa_off    = awaddr - A_BASE;
    wb_off    = awaddr - B_BASE;
    wr_ctrl   = wr_en && (awaddr == '0);
    wr_a      = wr_en && (awaddr >= A_BASE) && (awaddr < B_BASE);
    wr_b      = wr_en && (awaddr >= B_BASE) && (awaddr < C_BASE);
    start_acc = wr_ctrl && wdata[0] && idle;
    err_set   = (wr_ctrl && wdata[0] && !idle) || ((wr_a || wr_b) && !idle);
  end

  // Datapath: one A element broadcast against a B row, SIZE parallel MACs
  always_comb begin
    a_idx = IW'(32'(i_q)*32'(SIZE) + 32'(k_q));
    for (int unsigned j = 0; j < SIZE; j++) begin
      b_idx[j] = IW'(32'(k_q)*32'(SIZE) + j);
      c_idx[j] = IW'(32'(i_q)*32'(SIZE) + j);
      mac[j]   = c_q[c_idx[j]] + ext(a_q[a_idx], sgn_q) * ext(b_q[b_idx[j]], sgn_q);
    end
  end

  // Next-state logic for FSM, loop counters and status flags
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    acc_d   = acc_q;
    sgn_d   = sgn_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = wdata[1] ? S_RUN : S_CLEAR;
          acc_d   = wdata[1];
          sgn_d   = wdata[2];
        end
      end
      S_CLEAR: state_d = S_RUN;
      S_RUN: begin
        if (k_q == CMAX) begin
          k_d = '0;
          if (i_q == CMAX) begin
            i_d     = '0;
            state_d = S_FIN;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Clears are applied first so a same-cycle set takes priority
    if (wr_ctrl && wdata[3]) done_d = 1'b0;
    if (state_q == S_FIN)    done_d = 1'b1;
    if (wr_ctrl && wdata[4]) err_d  = 1'b0;
    if (err_set)             err_d  = 1'b1;
  end

  // Read decode; response is registered one cycle later
  always_comb begin
    ra_off  = araddr - A_BASE;
    rb_off  = araddr - B_BASE;
    rc_off  = araddr - C_BASE;
    rdata_d = '0;
    if (araddr == '0)
      rdata_d = {27'b0, sgn_q, acc_q, err_q, done_q, !idle};
    else if (araddr < B_BASE)
      rdata_d = 32'(a_q[ra_off[IW-1:0]]);
    else if (araddr < C_BASE)
      rdata_d = 32'(b_q[rb_off[IW-1:0]]);
    else if (araddr < U_BASE)
      rdata_d = cext(c_q[rc_off[IW-1:0]], sgn_q);
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= 1'b0;
      sgn_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      sgn_q    <= sgn_d;
      rvalid_q <= arvalid;
      rdata_q  <= rdata_d;
    end
  end

  // Operand and result storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned n = 0; n < NE; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      if (wr_a && idle) a_q[wa_off[IW-1:0]] <= wdata[DATA_W-1:0];
      if (wr_b && idle) b_q[wb_off[IW-1:0]] <= wdata[DATA_W-1:0];
      if (state_q == S_CLEAR) begin
        for (int unsigned n = 0; n < NE; n++) c_q[n] <= '0;
      end else if (state_q == S_RUN) begin
        for (int unsigned j = 0; j < SIZE; j++) c_q[c_idx[j]] <= mac[j];
      end
    end
  end

endmodule

// File: tb/tb_mxu_engine.sv
// Directed self-checking bench for mxu_engine (SIZE=4, DATA_W=8).
module tb_mxu_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, wvalid, awready, wready, arvalid, rvalid, irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mxu_engine #(.SIZE(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wvalid(wvalid),
    .awready(awready), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .rdata(rdata), .rvalid(rvalid),
    .irq(irq)
  );

  localparam logic [31:0] A0 = 32'd1;
  localparam logic [31:0] B0 = 32'd17;
  localparam logic [31:0] C0 = 32'd33;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output logic ack);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    #1 ack = awready & wready;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    araddr = addr; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    data = rvalid ? rdata : 32'hDEAD_BEEF;
  endtask

  // Poll STATUS every cycle; count responses with busy=1 until busy drops
  task automatic run_count(output int cnt);
    cnt = 0;
    araddr = '0; arvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rvalid && rdata[0]) cnt++;
      else if (rvalid) break;
    end
    arvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        ack;
    logic [31:0] d;
    int          cnt;

    reset = 1'b0; awaddr = '0; wdata = '0; awvalid = 1'b0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_irq", irq, 0);
    check("rst_rvalid", rvalid, 0);
    reset = 1'b1;
    @(negedge clk);
    rd(0, d); check("rst_status", d, 32'h0);

    // A = identity, B[k][j] = 4k+j+1, plain multiply
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        wr(A0 + 32'(i*4 + k), (i == k) ? 32'd1 : 32'd0, ack);
        wr(B0 + 32'(i*4 + k), 32'(4*i + k + 1), ack);
      end
    wr(0, 32'h1, ack); check("ack_start", ack, 1);
    run_count(cnt); check("busy_cycles_mul", cnt, 18);
    rd(0, d); check("status_done", d, 32'h02);
    check("irq_done", irq, 1);
    for (int n = 0; n < 16; n++) begin
      rd(C0 + 32'(n), d); check($sformatf("c_mul_%0d", n), d, 32'(n + 1));
    end

    // Accumulate a second product on top
    wr(0, 32'h3, ack);
    run_count(cnt); check("busy_cycles_acc", cnt, 17);
    rd(0, d); check("status_acc", d, 32'h0A);
    for (int n = 0; n < 16; n++) begin
      rd(C0 + 32'(n), d); check($sformatf("c_acc_%0d", n), d, 32'(2*(n + 1)));
    end

    // A all 0xFF, B all 0x02: signed then unsigned
    for (int n = 0; n < 16; n++) begin
      wr(A0 + 32'(n), 32'hABCD_00FF, ack);
      wr(B0 + 32'(n), 32'h0000_0002, ack);
    end
    rd(A0 + 5, d); check("a_trunc", d, 32'h0000_00FF);
    wr(0, 32'h5, ack);
    run_count(cnt); check("busy_cycles_sgn", cnt, 18);
    rd(0, d); check("status_sgn", d, 32'h12);
    for (int n = 0; n < 16; n += 5) begin
      rd(C0 + 32'(n), d); check($sformatf("c_sgn_%0d", n), d, 32'hFFFF_FFF8);
    end
    wr(0, 32'h9, ack);
    rd(0, d); check("status_clrdone_busy", d, 32'h01);
    run_count(cnt); check("busy_cycles_uns", cnt, 17);
    for (int n = 0; n < 16; n += 5) begin
      rd(C0 + 32'(n), d); check($sformatf("c_uns_%0d", n), d, 32'd2040);
    end

    // Writes while busy are acked, dropped, and flag err
    wr(0, 32'h1, ack);
    wr(A0, 32'h55, ack); check("ack_busy_a", ack, 1);
    wr(0, 32'h1, ack);   check("ack_busy_ctrl", ack, 1);
    run_count(cnt); check("busy_cycles_err", cnt, 16);
    rd(0, d); check("status_err", d, 32'h06);
    rd(A0, d); check("a00_unchanged", d, 32'h0000_00FF);
    rd(C0 + 7, d); check("c_err_run", d, 32'd2040);
    wr(0, 32'h10, ack);
    rd(0, d); check("status_clr_err", d, 32'h02);

    // C and unmapped writes are silently dropped
    wr(C0, 32'h1234, ack); check("ack_c_write", ack, 1);
    wr(32'd200, 32'h5, ack);
    rd(C0, d); check("c_write_dropped", d, 32'd2040);
    rd(0, d); check("status_no_err", d, 32'h02);

    // Back-to-back reads, one response per cycle
    araddr = 0; arvalid = 1'b1;
    @(negedge clk);
    check("b2b_v0", rvalid, 1); check("b2b_d0", rdata, 32'h02);
    araddr = C0;
    @(negedge clk);
    check("b2b_v1", rvalid, 1); check("b2b_d1", rdata, 32'd2040);
    araddr = 32'd100;
    @(negedge clk);
    check("b2b_v2", rvalid, 1); check("b2b_d2", rdata, 32'h0);
    arvalid = 1'b0;
    @(negedge clk);
    check("b2b_v3", rvalid, 0);

    // Asynchronous reset mid-run
    wr(0, 32'h1, ack);
    araddr = 0; arvalid = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_rvalid", rvalid, 1);
    check("pre_rst_irq", irq, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rvalid", rvalid, 0);
    check("async_irq", irq, 0);
    check("async_rdata", rdata, 32'h0);
    arvalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd(0, d); check("post_rst_status", d, 32'h0);
    rd(C0 + 6, d); check("post_rst_c12", d, 32'h0);
    rd(A0, d); check("post_rst_a00", d, 32'h0);
    rd(B0 + 15, d); check("post_rst_b33", d, 32'h0);
    repeat (30) @(negedge clk);
    check("no_done_after_abort", irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
